// File: rtl/mat_wb_seq_pkg.sv
// rtl/mat_wb_seq_pkg.sv - shared matrix-pipeline types: write-select codes, sequencer states, size defaults
package mat_wb_seq_pkg;

  localparam int MAT_DIM_DEF  = 4;
  localparam int MREG_NUM_DEF = 4;

  typedef enum logic [1:0] {
    WSEL_NONE  = 2'b00,
    WSEL_REG   = 2'b01,
    WSEL_SLICE = 2'b10,
    WSEL_MAT   = 2'b11
  } wsel_e;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

endpackage

// File: rtl/mat_wb_rowbuf.sv
// rtl/mat_wb_rowbuf.sv - captured whole-matrix buffer with a row read mux
module mat_wb_rowbuf
  import mat_wb_seq_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MAT_DIM = MAT_DIM_DEF
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              load,
  input  logic [MAT_DIM*MAT_DIM*XLEN-1:0]   mat_data,
  input  logic [$clog2(MAT_DIM)-1:0]        row_sel,
  output logic [MAT_DIM*XLEN-1:0]           row_data
);

  localparam int ROW_W = MAT_DIM * XLEN;

  logic [ROW_W-1:0] rows_q [MAT_DIM];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MAT_DIM; i++) rows_q[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < MAT_DIM; i++) rows_q[i] <= mat_data[i*ROW_W +: ROW_W];
    end
  end

  assign row_data = rows_q[row_sel];

endmodule

// File: rtl/mat_wb_seq.sv
// rtl/mat_wb_seq.sv - WB-stage writeback sequencer: scalar, slice and serialised whole-matrix writes
// Optional MAT_WB_PERF_EN adds the stall_cnt performance counter.
module mat_wb_seq
  import mat_wb_seq_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MAT_DIM  = MAT_DIM_DEF,
  parameter int MREG_NUM = MREG_NUM_DEF
) (
  input  logic                              clk,
  input  logic                              rstn,
  input  logic                              wb_valid,
  output logic                              wb_ready,
  input  logic [1:0]                        w_select,
  input  logic [4:0]                        rd,
  input  logic [$clog2(MAT_DIM)-1:0]        slice_idx,
  input  logic [XLEN-1:0]                   wb_data,
  input  logic [MAT_DIM*XLEN-1:0]           slice_data,
  input  logic [MAT_DIM*MAT_DIM*XLEN-1:0]   mat_data,
  output logic                              reg_we,
  output logic [4:0]                        reg_waddr,
  output logic [XLEN-1:0]                   reg_wdata,
  output logic                              mrf_we,
  output logic [$clog2(MREG_NUM)-1:0]       mrf_waddr,
  output logic [$clog2(MAT_DIM)-1:0]        mrf_row,
  output logic [MAT_DIM*XLEN-1:0]           mrf_wdata,
  output logic                              busy
`ifdef MAT_WB_PERF_EN
  ,
  output logic [31:0]                       stall_cnt
`endif
);

  localparam int RW    = $clog2(MAT_DIM);
  localparam int MW    = $clog2(MREG_NUM);
  localparam int ROW_W = MAT_DIM * XLEN;

  state_e            state_q, state_d;
  logic [RW-1:0]     cnt_q, cnt_d;
  logic [MW-1:0]     midx_q, midx_d;
  wsel_e             wsel;
  logic              accept, last_row, load;
  logic [ROW_W-1:0]  row_data;

  logic              reg_we_d, mrf_we_d;
  logic [4:0]        reg_waddr_d;
  logic [XLEN-1:0]   reg_wdata_d;
  logic [MW-1:0]     mrf_waddr_d;
  logic [RW-1:0]     mrf_row_d;
  logic [ROW_W-1:0]  mrf_wdata_d;

  assign wsel     = wsel_e'(w_select);
  assign last_row = (cnt_q == RW'(MAT_DIM - 1));
  assign wb_ready = (state_q == IDLE) || (state_q == BURST && last_row);
  assign accept   = wb_valid && wb_ready;
  assign load     = accept && (wsel == WSEL_MAT);
  assign busy     = (state_q == BURST);

  // cnt is the row currently on the outputs, so the mux looks one row ahead
  mat_wb_rowbuf #(
    .XLEN    (XLEN),
    .MAT_DIM (MAT_DIM)
  ) u_rowbuf (
    .clk      (clk),
    .rstn     (rstn),
    .load     (load),
    .mat_data (mat_data),
    .row_sel  (cnt_q + RW'(1)),
    .row_data (row_data)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      midx_q    <= '0;
      reg_we    <= 1'b0;
      reg_waddr <= '0;
      reg_wdata <= '0;
      mrf_we    <= 1'b0;
      mrf_waddr <= '0;
      mrf_row   <= '0;
      mrf_wdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      midx_q    <= midx_d;
      reg_we    <= reg_we_d;
      reg_waddr <= reg_waddr_d;
      reg_wdata <= reg_wdata_d;
      mrf_we    <= mrf_we_d;
      mrf_waddr <= mrf_waddr_d;
      mrf_row   <= mrf_row_d;
      mrf_wdata <= mrf_wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (load) state_d = BURST;
      BURST: if (last_row) state_d = load ? BURST : IDLE;
    endcase
  end

  // accepts only happen in IDLE or the final burst row, so they never collide with a burst row write
  always_comb begin
    reg_we_d    = 1'b0;
    reg_waddr_d = reg_waddr;
    reg_wdata_d = reg_wdata;
    mrf_we_d    = 1'b0;
    mrf_waddr_d = mrf_waddr;
    mrf_row_d   = mrf_row;
    mrf_wdata_d = mrf_wdata;
    cnt_d       = cnt_q;
    midx_d      = midx_q;

    if (state_q == BURST && !last_row) begin
      mrf_we_d    = 1'b1;
      mrf_waddr_d = midx_q;
      mrf_row_d   = cnt_q + RW'(1);
      mrf_wdata_d = row_data;
      cnt_d       = cnt_q + RW'(1);
    end

    if (accept) begin
      unique case (wsel)
        WSEL_REG: begin
          if (rd != 5'd0) begin
            reg_we_d    = 1'b1;
            reg_waddr_d = rd;
            reg_wdata_d = wb_data;
          end
        end
        WSEL_SLICE: begin
          mrf_we_d    = 1'b1;
          mrf_waddr_d = rd[MW-1:0];
          mrf_row_d   = slice_idx;
          mrf_wdata_d = slice_data;
        end
        WSEL_MAT: begin
          // row 0 goes out straight from the input; the buffer is not loaded until this edge
          mrf_we_d    = 1'b1;
          mrf_waddr_d = rd[MW-1:0];
          mrf_row_d   = '0;
          mrf_wdata_d = mat_data[ROW_W-1:0];
          cnt_d       = '0;
          midx_d      = rd[MW-1:0];
        end
        WSEL_NONE: ;
      endcase
    end
  end

`ifdef MAT_WB_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                     stall_cnt <= '0;
    else if (wb_valid && !wb_ready) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_mat_wb_seq.sv
// tb/tb_mat_wb_seq.sv - directed self-checking bench for mat_wb_seq
module tb_mat_wb_seq;

  localparam int XLEN     = 32;
  localparam int MAT_DIM  = 4;
  localparam int MREG_NUM = 4;
  localparam int ROW_W    = MAT_DIM * XLEN;
  localparam int MAT_W    = MAT_DIM * ROW_W;

  logic              clk = 1'b0;
  logic              rstn;
  logic              wb_valid;
  logic              wb_ready;
  logic [1:0]        w_select;
  logic [4:0]        rd;
  logic [1:0]        slice_idx;
  logic [XLEN-1:0]   wb_data;
  logic [ROW_W-1:0]  slice_data;
  logic [MAT_W-1:0]  mat_data;
  logic              reg_we;
  logic [4:0]        reg_waddr;
  logic [XLEN-1:0]   reg_wdata;
  logic              mrf_we;
  logic [1:0]        mrf_waddr;
  logic [1:0]        mrf_row;
  logic [ROW_W-1:0]  mrf_wdata;
  logic              busy;
`ifdef MAT_WB_PERF_EN
  logic [31:0]       stall_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mat_wb_seq #(
    .XLEN     (XLEN),
    .MAT_DIM  (MAT_DIM),
    .MREG_NUM (MREG_NUM)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .w_select   (w_select),
    .rd         (rd),
    .slice_idx  (slice_idx),
    .wb_data    (wb_data),
    .slice_data (slice_data),
    .mat_data   (mat_data),
    .reg_we     (reg_we),
    .reg_waddr  (reg_waddr),
    .reg_wdata  (reg_wdata),
    .mrf_we     (mrf_we),
    .mrf_waddr  (mrf_waddr),
    .mrf_row    (mrf_row),
    .mrf_wdata  (mrf_wdata),
    .busy       (busy)
`ifdef MAT_WB_PERF_EN
    ,
    .stall_cnt  (stall_cnt)
`endif
  );

  task automatic check(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ROW_W-1:0] mrow(input int r);
    logic [31:0] w;
    w = 32'(r + 1);
    return {w, w, w, w};
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, " wb_ready"},  ROW_W'(wb_ready),  ROW_W'(1));
    check({tag, " busy"},      ROW_W'(busy),      ROW_W'(0));
    check({tag, " reg_we"},    ROW_W'(reg_we),    ROW_W'(0));
    check({tag, " reg_waddr"}, ROW_W'(reg_waddr), ROW_W'(0));
    check({tag, " reg_wdata"}, ROW_W'(reg_wdata), ROW_W'(0));
    check({tag, " mrf_we"},    ROW_W'(mrf_we),    ROW_W'(0));
    check({tag, " mrf_waddr"}, ROW_W'(mrf_waddr), ROW_W'(0));
    check({tag, " mrf_row"},   ROW_W'(mrf_row),   ROW_W'(0));
    check({tag, " mrf_wdata"}, mrf_wdata,         ROW_W'(0));
`ifdef MAT_WB_PERF_EN
    check({tag, " stall_cnt"}, ROW_W'(stall_cnt), ROW_W'(0));
`endif
  endtask

  task automatic start_matrix(input logic [4:0] idx);
    wb_valid = 1'b1;
    w_select = 2'b11;
    rd       = idx;
    for (int r = 0; r < MAT_DIM; r++) mat_data[r*ROW_W +: ROW_W] = mrow(r);
  endtask

  initial begin
    int pulses;
    rstn = 1'b0; wb_valid = 1'b0; w_select = 2'b00; rd = '0; slice_idx = '0;
    wb_data = '0; slice_data = '0; mat_data = '0;
    tick; tick;
    rstn = 1'b1;
    check_idle_outputs("reset");

    // scalar write rd=5
    wb_valid = 1'b1; w_select = 2'b01; rd = 5'd5; wb_data = 32'hDEADBEEF;
    tick;
    wb_valid = 1'b0;
    check("reg T+1 we",    ROW_W'(reg_we),    ROW_W'(1));
    check("reg T+1 waddr", ROW_W'(reg_waddr), ROW_W'(5));
    check("reg T+1 wdata", ROW_W'(reg_wdata), ROW_W'(32'hDEADBEEF));
    check("reg T+1 mrf_we", ROW_W'(mrf_we),   ROW_W'(0));
    tick;
    check("reg T+2 we",    ROW_W'(reg_we),    ROW_W'(0));

    // scalar write to x0 suppressed
    wb_valid = 1'b1; rd = 5'd0;
    tick;
    wb_valid = 1'b0;
    check("x0 we",         ROW_W'(reg_we),    ROW_W'(0));

    // slice write
    wb_valid = 1'b1; w_select = 2'b10; rd = 5'd2; slice_idx = 2'd3;
    slice_data = 128'h1111_2222_3333_4444;
    tick;
    wb_valid = 1'b0;
    check("slice we",      ROW_W'(mrf_we),    ROW_W'(1));
    check("slice waddr",   ROW_W'(mrf_waddr), ROW_W'(2));
    check("slice row",     ROW_W'(mrf_row),   ROW_W'(3));
    check("slice data",    mrf_wdata,         128'h1111_2222_3333_4444);
    check("slice reg_we",  ROW_W'(reg_we),    ROW_W'(0));
    tick;
    check("slice T+2 we",  ROW_W'(mrf_we),    ROW_W'(0));

    // whole matrix, then a scalar request held through the burst
    start_matrix(5'd1);
    check("mat accept ready", ROW_W'(wb_ready), ROW_W'(1));
    tick;
    mat_data = {MAT_W{1'b1}};
    w_select = 2'b01; rd = 5'd7; wb_data = 32'hCAFE0001;
    for (int k = 0; k < MAT_DIM; k++) begin
      check($sformatf("burst %0d we", k),    ROW_W'(mrf_we),    ROW_W'(1));
      check($sformatf("burst %0d row", k),   ROW_W'(mrf_row),   ROW_W'(k));
      check($sformatf("burst %0d data", k),  mrf_wdata,         mrow(k));
      check($sformatf("burst %0d waddr", k), ROW_W'(mrf_waddr), ROW_W'(1));
      check($sformatf("burst %0d busy", k),  ROW_W'(busy),      ROW_W'(1));
      check($sformatf("burst %0d ready", k), ROW_W'(wb_ready),  ROW_W'(k == MAT_DIM - 1));
      check($sformatf("burst %0d reg_we", k), ROW_W'(reg_we),   ROW_W'(0));
      tick;
    end
    wb_valid = 1'b0;
    check("b2b reg_we",    ROW_W'(reg_we),    ROW_W'(1));
    check("b2b waddr",     ROW_W'(reg_waddr), ROW_W'(7));
    check("b2b wdata",     ROW_W'(reg_wdata), ROW_W'(32'hCAFE0001));
    check("b2b mrf_we",    ROW_W'(mrf_we),    ROW_W'(0));
    check("b2b busy",      ROW_W'(busy),      ROW_W'(0));
`ifdef MAT_WB_PERF_EN
    check("stall_cnt",     ROW_W'(stall_cnt), ROW_W'(3));
`endif
    tick;

    // reset while row 1 of a burst is on the outputs
    start_matrix(5'd3);
    tick;
    wb_valid = 1'b0;
    tick;
    check("abort pre row", ROW_W'(mrf_row),   ROW_W'(1));
    rstn = 1'b0;
    #1;
    check("abort async we", ROW_W'(mrf_we),   ROW_W'(0));
    tick;
    rstn = 1'b1;
    pulses = 0;
    for (int k = 0; k < MAT_DIM + 1; k++) begin
      if (mrf_we) pulses++;
      tick;
    end
    check("abort pulses",  ROW_W'(pulses),    ROW_W'(0));
    check_idle_outputs("post abort");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
